entropy_collector: RTL
======================

Name: entropy_collector

Overview:
- Parametrised successor to the single-stream ring-oscillator collector.
- Takes one asynchronous entropy bit, synchronises it, and runs a runtime-selectable post-processor: raw, von Neumann or XOR-pair.
- Packs the resulting bits into WORD_WIDTH-bit words, buffers them in a FIFO, and presents them on a valid/ready interface to the UART/host side.
- Adds a repetition-count health test and overflow accounting. Full words are never duplicated or partially overwritten.

Parameters:
WORD_WIDTH, 8, bits per output word (1..32).
FIFO_DEPTH, 16, output FIFO entries (power of 2, >=2).
RCT_LIMIT, 64, consecutive identical synchronised samples that trip health_fail (>=2).

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
raw_bit  in  1  asynchronous entropy input (ring-oscillator XOR)
enable  in  1  1 = collect bits; 0 = halt collection
mode  in  2  0 raw, 1 von Neumann, 2 XOR-pair, 3 treated as von Neumann
out_data  out  WORD_WIDTH  head-of-FIFO word
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts out_data when out_valid & out_ready
drop_count  out  16  words discarded because the FIFO was full; saturates at 0xFFFF
health_fail  out  1  sticky repetition-count failure
stat_ones  out  16  ones among the last 65536 accepted bits (optional feature)
stat_valid  out  1  pulse when stat_ones updates (optional feature)

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - Cleared: out_valid, out_data, drop_count, health_fail, stat_ones, stat_valid, the synchroniser, pair phase, bit counter, RCT counter, and the FIFO pointers.
  - Reset mid-word discards the partial word.
- Synchroniser:
  - raw_bit passes through 2 flops; the output s is the sample.
  - All processing uses s. The 2-cycle synchroniser latency is not otherwise counted.
- Post-processing (each cycle with enable=1 and health_fail=0):
  - Raw: s is accepted every cycle.
  - Pairing for the other modes: the pair phase toggles every cycle. Phase 0 stores a=s. Phase 1 takes b=s.
  - Von Neumann: accept a if a!=b; discard the pair if a==b.
  - XOR-pair: accept a^b every pair.
- Packing:
  - Accepted bits are written LSB first into a shift/index register. The bit counter runs 0..WORD_WIDTH-1.
  - On the edge that captures bit WORD_WIDTH-1, the full word is written into the FIFO and the counter returns to 0.
  - out_valid rises on the following cycle if the FIFO was empty.
- FIFO:
  - Registered first-word-fall-through. out_data is stable while out_valid=1 and out_ready=0.
  - Pop occurs on an edge with out_valid & out_ready.
  - Push while full with no pop in the same cycle: the word is dropped and drop_count increments (saturating).
  - Push while full with a simultaneous pop: the push is accepted and the count is unchanged.
  - Push and pop while empty: no bypass. out_valid rises next cycle.
- enable=0:
  - Pair phase, bit counter and partial word are cleared; the FIFO still drains.
  - On re-enable, the first sample lands in phase 0 / bit 0.
- mode change (mode differs from its registered value):
  - Same clearing as enable=0 for that cycle.
  - Bits collected under different modes never share a word.
- Health test:
  - The RCT counter increments when s equals the previous s and reloads to 1 otherwise.
  - When the counter reaches RCT_LIMIT, health_fail is set on that edge.
  - While health_fail=1, no bits are accepted and the partial word is discarded. Words already in the FIFO still drain.
  - Cleared only by reset. The health test runs regardless of mode. It is gated only by enable: the counter holds at 1 when enable=0.

Optional Feature:
- Macro RNG_STATS_EN.
- When defined:
  - A 16-bit accepted-bit counter and a 17-bit ones counter run.
  - Each time 65536 accepted bits have elapsed, stat_ones latches the ones count (0xFFFF if all were ones), stat_valid pulses for 1 cycle, and both counters restart.
- When undefined: stat_ones=0 and stat_valid=0 are constant. The ports remain present.

Test Plan:
1. Raw mode, WORD_WIDTH=8, enable=1, out_ready=1; s sequence 1,0,1,1,0,0,0,1 -> one word out_data=0x8D, out_valid for exactly 1 cycle.
2. Mode 1; 8 pairs (1,0) then 8 pairs (0,1) with pairs (1,1),(0,0) interleaved -> words 0xFF then 0x00, no other words.
3. FIFO_DEPTH=4, out_ready=0, 6 words generated -> 4 stored, drop_count=2. Then out_ready=1 -> the first 4 words in order, out_valid then low.
4. RCT_LIMIT=64, s held at 1 -> health_fail=1 on the 64th identical sample. No further words; the existing FIFO contents drain; only reset clears the failure.
5. Raw mode, reset_n low 1 cycle after 5 bits of a word -> all outputs at reset values. The next 8 bits form a complete fresh word (no stale bits).
6. Switch mode 0->2 after 3 bits -> partial word discarded. The next word is built solely from XOR-pair bits (pairs (1,0)x8 -> 0xFF).

Source files
------------

// File: rtl/entropy_collector.sv
// entropy_collector: synchronised entropy bit -> post-processor -> word packer -> FIFO.
// Optional build macro RNG_STATS_EN enables the ones-count statistics block.
module entropy_collector #(
   parameter int WORD_WIDTH = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int RCT_LIMIT  = 64
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  raw_bit,
   input  logic                  enable,
   input  logic [1:0]            mode,
   output logic [WORD_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [15:0]           drop_count,
   output logic                  health_fail,
   output logic [15:0]           stat_ones,
   output logic                  stat_valid
);

   localparam int CW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int RW = $clog2(RCT_LIMIT + 1);

   localparam logic [1:0] MODE_RAW = 2'd0;
   localparam logic [1:0] MODE_XOR = 2'd2;

   logic                  sync1_q, sync1_d;
   logic                  sync2_q, sync2_d;
   logic                  s;

   logic                  prev_s_q, prev_s_d;
   logic [RW-1:0]         rct_cnt_q, rct_cnt_d;
   logic                  health_fail_q, health_fail_d;

   logic [1:0]            mode_q, mode_d;
   logic                  phase_q, phase_d;
   logic                  a_q, a_d;
   logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [WORD_WIDTH-1:0] word_q, word_d;

   logic                  mode_chg;
   logic                  collect;
   logic                  acc;
   logic                  abit;
   logic                  push;
   logic [WORD_WIDTH-1:0] push_word;

   logic [WORD_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [WORD_WIDTH-1:0] mem_d [FIFO_DEPTH];
   logic [AW:0]           wptr_q, wptr_d;
   logic [AW:0]           rptr_q, rptr_d;
   logic [15:0]           drop_q, drop_d;
   logic                  empty;
   logic                  full;
   logic                  pop;
   logic                  wr;

   // Two-flop synchroniser for the asynchronous ring-oscillator bit.
   always_comb begin
      sync1_d = raw_bit;
      sync2_d = sync1_q;
      s       = sync2_q;
   end

   // Repetition-count test; counter parks at 1 while collection is halted.
   always_comb begin
      prev_s_d      = s;
      rct_cnt_d     = rct_cnt_q;
      health_fail_d = health_fail_q;
      if (!enable) begin
         rct_cnt_d = RW'(1);
      end else if (s == prev_s_q) begin
         if (rct_cnt_q != RW'(RCT_LIMIT))
            rct_cnt_d = rct_cnt_q + RW'(1);
      end else begin
         rct_cnt_d = RW'(1);
      end
      if (enable && rct_cnt_d == RW'(RCT_LIMIT))
         health_fail_d = 1'b1;
   end

   // Post-processing and LSB-first packing; any halt drops the partial word.
   always_comb begin
      mode_d    = mode;
      mode_chg  = (mode != mode_q);
      collect   = enable & ~health_fail_q & ~mode_chg;
      phase_d   = phase_q;
      a_d       = a_q;
      bit_cnt_d = bit_cnt_q;
      word_d    = word_q;
      acc       = 1'b0;
      abit      = 1'b0;
      push      = 1'b0;
      push_word = word_q;
      if (!collect) begin
         phase_d   = 1'b0;
         bit_cnt_d = '0;
         word_d    = '0;
      end else begin
         if (mode_q == MODE_RAW) begin
            acc  = 1'b1;
            abit = s;
         end else if (!phase_q) begin
            phase_d = 1'b1;
            a_d     = s;
         end else begin
            phase_d = 1'b0;
            if (mode_q == MODE_XOR) begin
               acc  = 1'b1;
               abit = a_q ^ s;
            end else begin
               acc  = (a_q != s);
               abit = a_q;
            end
         end
         if (acc) begin
            push_word[bit_cnt_q] = abit;
            if (bit_cnt_q == CW'(WORD_WIDTH - 1)) begin
               push      = 1'b1;
               bit_cnt_d = '0;
               word_d    = '0;
            end else begin
               bit_cnt_d = bit_cnt_q + CW'(1);
               word_d    = push_word;
            end
         end
      end
   end

   // FIFO bookkeeping: a full FIFO only takes a word if it pops that cycle.
   always_comb begin
      empty  = (wptr_q == rptr_q);
      full   = (wptr_q[AW] != rptr_q[AW]) &&
               (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
      pop    = ~empty & out_ready;
      wr     = push & (~full | pop);
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      drop_d = drop_q;
      if (wr) begin
         mem_d[wptr_q[AW-1:0]] = push_word;
         wptr_d = wptr_q + (AW+1)'(1);
      end
      if (pop)
         rptr_d = rptr_q + (AW+1)'(1);
      if (push && full && !pop && drop_q != 16'hFFFF)
         drop_d = drop_q + 16'd1;
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1_q       <= 1'b0;
         sync2_q       <= 1'b0;
         prev_s_q      <= 1'b0;
         rct_cnt_q     <= '0;
         health_fail_q <= 1'b0;
         mode_q        <= MODE_RAW;
         phase_q       <= 1'b0;
         a_q           <= 1'b0;
         bit_cnt_q     <= '0;
         word_q        <= '0;
         mem_q         <= '{default: '0};
         wptr_q        <= '0;
         rptr_q        <= '0;
         drop_q        <= '0;
      end else begin
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         prev_s_q      <= prev_s_d;
         rct_cnt_q     <= rct_cnt_d;
         health_fail_q <= health_fail_d;
         mode_q        <= mode_d;
         phase_q       <= phase_d;
         a_q           <= a_d;
         bit_cnt_q     <= bit_cnt_d;
         word_q        <= word_d;
         mem_q         <= mem_d;
         wptr_q        <= wptr_d;
         rptr_q        <= rptr_d;
         drop_q        <= drop_d;
      end
   end

   assign out_valid   = ~empty;
   assign out_data    = empty ? '0 : mem_q[rptr_q[AW-1:0]];
   assign drop_count  = drop_q;
   assign health_fail = health_fail_q;

`ifdef RNG_STATS_EN
   logic [15:0] st_cnt_q, st_cnt_d;
   logic [16:0] st_ones_q, st_ones_d;
   logic [15:0] stat_ones_q, stat_ones_d;
   logic        stat_valid_q, stat_valid_d;
   logic [16:0] ones_sum;

   // Ones count over each window of 65536 accepted bits.
   always_comb begin
      st_cnt_d     = st_cnt_q;
      st_ones_d    = st_ones_q;
      stat_ones_d  = stat_ones_q;
      stat_valid_d = 1'b0;
      ones_sum     = st_ones_q + {16'd0, abit};
      if (acc) begin
         if (st_cnt_q == 16'hFFFF) begin
            stat_ones_d  = ones_sum[16] ? 16'hFFFF : ones_sum[15:0];
            stat_valid_d = 1'b1;
            st_cnt_d     = '0;
            st_ones_d    = '0;
         end else begin
            st_cnt_d  = st_cnt_q + 16'd1;
            st_ones_d = ones_sum;
         end
      end
   end

   // Statistics registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         st_cnt_q     <= '0;
         st_ones_q    <= '0;
         stat_ones_q  <= '0;
         stat_valid_q <= 1'b0;
      end else begin
         st_cnt_q     <= st_cnt_d;
         st_ones_q    <= st_ones_d;
         stat_ones_q  <= stat_ones_d;
         stat_valid_q <= stat_valid_d;
      end
   end

   assign stat_ones  = stat_ones_q;
   assign stat_valid = stat_valid_q;
`else
   assign stat_ones  = 16'd0;
   assign stat_valid = 1'b0;
`endif

endmodule
